// File: rtl/f2_resp_checker.sv
// Response checker for the six-input f2 block: compares sampled DUT outputs against a
// golden truth table and accumulates errors, coverage and a MISR signature per sweep.
module f2_resp_checker #(
    parameter int                    N_IN     = 6,
    parameter logic [(1<<N_IN)-1:0]  GOLDEN   = 64'h6996_9669_9669_6996,
    parameter int                    TIMEOUT  = 1024,
    parameter logic [15:0]           SIG_POLY = 16'h1021,
    parameter logic [15:0]           SIG_SEED = 16'hFFFF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_in_valid,
    input  logic [N_IN-1:0] i_in_vec,
    input  logic            i_in_out,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic            o_timeout,
    output logic [15:0]     o_err_count,
    output logic [15:0]     o_dup_count,
    output logic [N_IN-1:0] o_first_fail_vec,
    output logic            o_first_fail_valid,
    output logic [15:0]     o_sig,
    output logic [1:0]      o_dbg_state
);

    localparam int DEPTH = 1 << N_IN;
    localparam int CW    = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DEPTH-1:0]  r_bitmap;
    logic [CW-1:0]     r_cyc;

    logic              w_sample;
    logic              w_mismatch;
    logic              w_dup;
    logic [DEPTH-1:0]  w_bitmap_next;
    logic              w_full_next;
    logic              w_tmo_hit;
    logic              w_accept_start;
    logic [15:0]       w_err_next;
    logic [15:0]       w_dup_next;
    logic              w_fb;
    logic [15:0]       w_sig_next;

    // Samples are only meaningful while a sweep is running.
    assign w_sample       = (r_state == S_RUN) && i_in_valid;
    assign w_mismatch     = w_sample && (i_in_out != GOLDEN[i_in_vec]);
    assign w_dup          = w_sample && r_bitmap[i_in_vec];
    assign w_bitmap_next  = r_bitmap | (w_sample ? (DEPTH'(1) << i_in_vec) : '0);
    assign w_full_next    = &w_bitmap_next;
    assign w_tmo_hit      = (r_state == S_RUN) && (r_cyc == CW'(TIMEOUT - 1));
    assign w_accept_start = (r_state != S_RUN) && i_start;

    assign w_err_next = (w_mismatch && (o_err_count != 16'hFFFF)) ? o_err_count + 16'd1 : o_err_count;
    assign w_dup_next = (w_dup && (o_dup_count != 16'hFFFF)) ? o_dup_count + 16'd1 : o_dup_count;
    assign w_fb       = o_sig[15] ^ i_in_out;
    assign w_sig_next = {o_sig[14:0], 1'b0} ^ (w_fb ? SIG_POLY : 16'h0000);

    assign o_busy      = (r_state == S_RUN);
    assign o_done      = (r_state == S_DONE);
    assign o_dbg_state = r_state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Completion on the same edge as the timeout takes priority.
                if (w_full_next || w_tmo_hit) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bitmap           <= '0;
            r_cyc              <= '0;
            o_pass             <= 1'b0;
            o_timeout          <= 1'b0;
            o_err_count        <= 16'h0000;
            o_dup_count        <= 16'h0000;
            o_first_fail_vec   <= '0;
            o_first_fail_valid <= 1'b0;
            o_sig              <= 16'h0000;
        end else if (w_accept_start) begin
            r_bitmap           <= '0;
            r_cyc              <= '0;
            o_pass             <= 1'b0;
            o_timeout          <= 1'b0;
            o_err_count        <= 16'h0000;
            o_dup_count        <= 16'h0000;
            o_first_fail_vec   <= '0;
            o_first_fail_valid <= 1'b0;
            o_sig              <= SIG_SEED;
        end else if (r_state == S_RUN) begin
            if (w_sample) begin
                r_bitmap    <= w_bitmap_next;
                o_err_count <= w_err_next;
                o_dup_count <= w_dup_next;
                o_sig       <= w_sig_next;
                if (w_mismatch && !o_first_fail_valid) begin
                    o_first_fail_vec   <= i_in_vec;
                    o_first_fail_valid <= 1'b1;
                end
            end
            if (w_full_next) begin
                o_pass <= (w_err_next == 16'h0000);
            end else if (w_tmo_hit) begin
                o_timeout <= 1'b1;
            end else begin
                r_cyc <= r_cyc + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_f2_resp_checker.sv
// Scoreboard bench for f2_resp_checker: a reference model predicts every output after
// each clock, predictions are queued at drive time and popped once the edge has passed.
module tb_f2_resp_checker;

    localparam int N_IN = 6;
    localparam int TMO  = 100;
    localparam int W    = 64;
    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_DONE = 2;

    logic            clk;
    logic            i_rst;
    logic            i_start;
    logic            i_in_valid;
    logic [N_IN-1:0] i_in_vec;
    logic            i_in_out;
    logic            o_busy, o_done, o_pass, o_timeout;
    logic [15:0]     o_err_count, o_dup_count, o_sig;
    logic [N_IN-1:0] o_first_fail_vec;
    logic            o_first_fail_valid;
    logic [1:0]      o_dbg_state;

    f2_resp_checker #(.N_IN(N_IN), .TIMEOUT(TMO)) u_dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_start            (i_start),
        .i_in_valid         (i_in_valid),
        .i_in_vec           (i_in_vec),
        .i_in_out           (i_in_out),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_pass             (o_pass),
        .o_timeout          (o_timeout),
        .o_err_count        (o_err_count),
        .o_dup_count        (o_dup_count),
        .o_first_fail_vec   (o_first_fail_vec),
        .o_first_fail_valid (o_first_fail_valid),
        .o_sig              (o_sig),
        .o_dbg_state        (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int              m_state;
    logic [63:0]     m_bm;
    int              m_cyc;
    logic            m_pass, m_to, m_ffv;
    logic [N_IN-1:0] m_ffvec;
    logic [15:0]     m_err, m_dup, m_sig;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_bm = '0; m_cyc = 0; m_pass = 0; m_to = 0;
        m_ffv = 0; m_ffvec = '0; m_err = '0; m_dup = '0; m_sig = '0;
    endtask

    task automatic model_edge(input bit st, input bit v, input logic [N_IN-1:0] vec, input bit out);
        logic mis;
        logic fb;
        if (m_state != ST_RUN) begin
            if (st) begin
                m_state = ST_RUN; m_bm = '0; m_cyc = 0; m_pass = 0; m_to = 0;
                m_ffv = 0; m_ffvec = '0; m_err = '0; m_dup = '0; m_sig = 16'hFFFF;
            end
        end else begin
            if (v) begin
                mis = (out != ^vec);  // golden is 6-input parity
                if (mis && m_err != 16'hFFFF) m_err++;
                if (mis && !m_ffv) begin m_ffv = 1; m_ffvec = vec; end
                if (m_bm[vec] && m_dup != 16'hFFFF) m_dup++;
                m_bm[vec] = 1'b1;
                fb = m_sig[15] ^ out;
                m_sig = {m_sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
            if (&m_bm) begin
                m_state = ST_DONE; m_pass = (m_err == 0);
            end else if (m_cyc == TMO - 1) begin
                m_state = ST_DONE; m_to = 1;
            end else begin
                m_cyc++;
            end
        end
    endtask

    function automatic logic [W-1:0] model_pack();
        logic [1:0] s;
        s = 2'(m_state);
        return {3'b0, s, (m_state == ST_RUN), (m_state == ST_DONE), m_pass, m_to,
                m_ffv, m_ffvec, m_err, m_dup, m_sig};
    endfunction

    task automatic compare_outputs(input logic [W-1:0] e);
        check("state", 64'(o_dbg_state), 64'(e[60:59]));
        check("flags", 64'({o_busy, o_done, o_pass, o_timeout}), 64'(e[58:55]));
        check("first_fail", 64'({o_first_fail_valid, o_first_fail_vec}), 64'(e[54:48]));
        check("err_count", 64'(o_err_count), 64'(e[47:32]));
        check("dup_count", 64'(o_dup_count), 64'(e[31:16]));
        check("sig", 64'(o_sig), 64'(e[15:0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit st, input bit v, input logic [N_IN-1:0] vec, input bit out);
        i_start = st; i_in_valid = v; i_in_vec = vec; i_in_out = out;
        model_edge(st, v, vec, out);
        exp_q.push_back(model_pack());
        @(posedge clk); #1;
        i_start = 0; i_in_valid = 0;
        if (exp_q.size() == 0) check("queue_underflow", 64'd0, 64'd1);
        else compare_outputs(exp_q.pop_front());
    endtask

    task automatic sample(input logic [N_IN-1:0] vec, input bit flip);
        cycle(1'b0, 1'b1, vec, (^vec) ^ flip);
    endtask

    task automatic async_reset();
        i_rst = 1; #2;
        model_reset();
        exp_q.push_back(model_pack());
        compare_outputs(exp_q.pop_front());
        @(posedge clk); #1;
        i_rst = 0;
        exp_q.push_back(model_pack());
        compare_outputs(exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    logic [15:0]     clean_sig;
    logic [N_IN-1:0] perm[64];
    logic [N_IN-1:0] tmp;
    int              n_run;

    initial begin
        i_rst = 1; i_start = 0; i_in_valid = 0; i_in_vec = '0; i_in_out = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(model_pack());
        compare_outputs(exp_q.pop_front());
        i_rst = 0;

        // clean in-order parity sweep
        cycle(1'b1, 1'b1, 6'd9, 1'b0);  // sample on the start cycle is ignored
        for (int i = 0; i < 64; i++) begin
            sample(6'(i), 1'b0);
            if (i == 62) check("done_before_last", 64'(o_done), 64'd0);
        end
        check("done_at_64", 64'(o_done), 64'd1);
        check("pass_clean", 64'(o_pass), 64'd1);
        clean_sig = m_sig;
        cycle(1'b0, 1'b1, 6'd3, 1'b1);  // samples in DONE are ignored

        // same sweep with vector 37 inverted; start from DONE reseeds sig
        cycle(1'b1, 1'b0, '0, 1'b0);
        check("sig_seed", 64'(o_sig), 64'hFFFF);
        for (int i = 0; i < 64; i++) sample(6'(i), i == 37);
        check("err_one", 64'(o_err_count), 64'd1);
        check("ffvec_37", 64'({o_first_fail_valid, o_first_fail_vec}), 64'({1'b1, 6'd37}));
        check("pass_bad", 64'(o_pass), 64'd0);
        check("sig_differs", 64'(o_sig != clean_sig), 64'd1);

        // toggle-style source starting mid-count, valid held for 64 cycles
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 64; i++) sample(6'(i + 17), 1'b0);
        check("pass_toggle", 64'(o_pass), 64'd1);

        // vector 5 thrice, then 0..62, then idle until timeout; start mid-RUN ignored
        cycle(1'b1, 1'b0, '0, 1'b0);
        n_run = 0;
        for (int i = 0; i < 3; i++) begin sample(6'd5, 1'b0); n_run++; end
        for (int i = 0; i < 63; i++) begin sample(6'(i), 1'b0); n_run++; end
        for (int k = 0; k < 200 && !o_done; k++) begin
            cycle(k == 10, 1'b0, '0, 1'b0);
            n_run++;
        end
        check("timeout_cycle", 64'(n_run), 64'(TMO));
        check("timeout_flag", 64'({o_done, o_timeout, o_pass}), 64'b110);
        check("dup_three", 64'(o_dup_count), 64'd3);

        // rst at sample 30 of a sweep, then a full shuffled clean sweep
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 30; i++) sample(6'(i), 1'b0);
        async_reset();
        for (int i = 0; i < 64; i++) perm[i] = 6'(i);
        for (int i = 63; i > 0; i--) begin
            int j;
            j = $urandom_range(i, 0);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            sample(perm[i], 1'b0);
            if (i == 20) cycle(1'b1, 1'b0, '0, 1'b0);  // start in RUN
        end
        check("pass_after_rst", 64'(o_pass), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/f2_resp_checker.md
# f2_resp_checker

Response checker for the six-input `f2` combinational block: the receiving end of the exhaustive-stimulus interface. It samples each applied input vector together with the DUT output and compares the output against a golden truth table. It accumulates mismatch count, coverage and a response signature, then reports pass/fail once all 2^N_IN vectors have been seen or a timeout expires. It sits in the `f2` self-test harness, downstream of the stimulus source and the DUT.

## Interface
- `N_IN`, 6: DUT input count; truth-table depth is 2^N_IN.
- `GOLDEN`, 64'h6996_9669_9669_6996: expected output; bit i is the value for vector i. The default is 6-input parity.
- `TIMEOUT`, 1024: RUN cycles allowed before forced completion.
- `SIG_POLY`, 16'h1021: MISR feedback polynomial.
- `SIG_SEED`, 16'hFFFF: MISR value loaded on start.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a sweep.
- `in_valid`  in  1  `in_vec`/`in_out` hold a sample this cycle.
- `in_vec`  in  N_IN  input vector applied to DUT (bit 0 = `a` … bit 5 = `f`).
- `in_out`  in  1  DUT output for `in_vec`.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  done, all vectors covered, zero mismatches, no timeout.
- `timeout`  out  1  sweep ended by TIMEOUT.
- `err_count`  out  16  mismatch count, saturating at 16'hFFFF.
- `dup_count`  out  16  samples whose vector was already covered, saturating.
- `first_fail_vec`  out  N_IN  vector of the first mismatch.
- `first_fail_valid`  out  1  `first_fail_vec` is meaningful.
- `sig`  out  16  MISR signature of `in_out` in arrival order.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: all outputs 0, coverage bitmap cleared, internal cycle counter 0. `sig` resets to 0. `SIG_SEED` is loaded only on start.
- IDLE or DONE with `start`=1 → RUN. On that edge, clear the counts, bitmap, `first_fail_*`, `timeout` and the cycle counter, and load `sig` with `SIG_SEED`. `in_valid` on the start cycle is ignored.
- `start` in RUN is ignored. `in_valid` in IDLE/DONE is ignored; all outputs hold.
- On each RUN cycle with `in_valid`=1:
  - expected = `GOLDEN[in_vec]`. On mismatch, `err_count`+1 (saturating).
  - If this is the first mismatch, latch `in_vec` into `first_fail_vec` and set `first_fail_valid`.
  - If the bitmap bit for `in_vec` is already set, `dup_count`+1; duplicates are still compared and counted as errors.
  - Set the bitmap bit.
  - MISR step: fb = `sig[15]` ^ `in_out`; `sig` ← {`sig[14:0]`,0} ^ (fb ? `SIG_POLY` : 0).
- Completion: when the bitmap is full, counting the sample on the current edge, go RUN → DONE on that same edge.
- Timeout: the cycle counter increments every RUN cycle. When it reaches TIMEOUT-1 without completion, go to DONE with `timeout`=1. If completion and timeout occur on the same edge, completion wins and `timeout`=0.
- `pass` = DONE & bitmap full & `err_count`==0 & !`timeout`.
- DONE holds all results until the next `start` or `rst`.

## Timing
- All outputs are registered. A sample on edge k is reflected in the counts, `sig` and `first_fail_*` after edge k (latency 1).
- `busy` rises on the edge that accepts `start`. `done` rises on the edge that registers the final vector. No bubble cycles; one sample is accepted per cycle.
- An `rst` assertion mid-RUN forces IDLE and reset values immediately, without waiting for a clock edge. Deassertion is synchronous to the system by harness convention.
- `err_count` and `dup_count` stick at 16'hFFFF once saturated.

## Test plan
- Parity DUT model, vectors 0..63 in order, one per cycle after start: `done` at the 64th sample edge, `pass`=1, `err_count`=0, `dup_count`=0, `sig` equals the bench MISR model.
- Same sweep with the response at vector 37 inverted: `err_count`=1, `first_fail_vec`=37, `first_fail_valid`=1, `pass`=0. `sig` differs from the clean run.
- Toggle-style source (`a` toggles every cycle, `b` every 2 cycles, … `f` every 32), `in_valid` held high for 64 cycles: full coverage, `done` after 64 samples, `pass`=1.
- Vectors 0..62 only, then `in_valid` low, TIMEOUT=100: `done` and `timeout`=1 at RUN cycle 100, `pass`=0. Repeating vector 5 three times before the sweep gives `dup_count`=3.
- `rst` pulsed at sample 30 of a sweep: all outputs 0, state IDLE. A subsequent `start` plus a full clean sweep gives `pass`=1.
- `start` pulsed mid-RUN has no effect. `start` in DONE restarts with cleared counts and `sig`=16'hFFFF.
